// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_queue_if : memory port, redirect and decode handshake    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface instr_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]       imem_addr;
    logic             imem_rd;
    logic [7:0]       imem_q;
    logic             redirect;
    logic [7:0]       redirect_pc;
    logic             out_ready;
    logic             out_valid;
    logic [7:0]       out_instr;
    logic [7:0]       out_pc;
    logic [CNT_W-1:0] occupancy;

    modport master (
        output imem_addr, imem_rd, out_valid, out_instr, out_pc, occupancy,
        input  imem_q, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, imem_rd, out_valid, out_instr, out_pc, occupancy,
        output imem_q, redirect, redirect_pc, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_queue : prefetching fetch stage with PC-tagged FIFO      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module instr_fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic                clock,
    input  logic                reset,
    instr_fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] pc;
    } entry_t;

    entry_t           buf_q [DEPTH];
    entry_t           buf_d [DEPTH];
    entry_t           head;
    logic [7:0]       fetch_pc_q, fetch_pc_d;
    logic [7:0]       inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             issue;
    logic             push;
    logic             pop;
    logic             head_valid;

    // An in-flight fetch reserves a slot, so issue never outruns free space.
    always_comb begin
        head_valid    = reset && !bus.redirect && (count_q != '0);
        issue         = reset && !bus.redirect &&
                        ((32'(count_q) + 32'(inflight_q)) < 32'(DEPTH));
        push          = inflight_q && !bus.redirect;
        pop           = head_valid && bus.out_ready;

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        buf_d         = buf_q;

        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 8'd1;
            end
            if (push) begin
                buf_d[wr_ptr_q] = '{instr: bus.imem_q, pc: inflight_pc_q};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clock) begin
        buf_q <= buf_d;
    end

    assign head          = buf_q[rd_ptr_q];
    assign bus.imem_addr = fetch_pc_q;
    assign bus.imem_rd   = issue;
    assign bus.out_valid = head_valid;
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
    assign bus.occupancy = count_q;

endmodule
`default_nettype wire
